// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// segment patterns {a,b,c,d,e,f,g,dp} (active-high) and scan FSM states.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1110_0110;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to 7-segment decoder; non-BCD nibbles render dark.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    // Map one BCD nibble to its segment pattern
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller. A written word waits in a
// one-entry pending buffer and is promoted to the displayed word only at a
// frame boundary (or at once while idle), so no frame mixes two words.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        lz_en,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [15:0]   act_q, act_d;
    logic          wr_ready_q, wr_ready_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          frame_done_q, frame_done_d;

    logic          accept, boundary, promote;
    logic [3:0]    cur_nib;
    logic [7:0]    cur_seg;
    logic          z3, z2, z1, suppress;

    assign accept   = wr_valid && wr_ready_q;
    assign boundary = en && (state_q == DRIVE) && (idx_q == 2'd0) && (cnt_q == SLOT_LAST);
    assign promote  = pend_full_q && ((state_q == IDLE) || boundary);

    assign cur_nib = act_q[{idx_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher digit are zero
    assign z3 = (act_q[15:12] == 4'd0);
    assign z2 = z3 && (act_q[11:8] == 4'd0);
    assign z1 = z2 && (act_q[7:4] == 4'd0);
    assign suppress = lz_en && (((idx_q == 2'd3) && z3) ||
                                ((idx_q == 2'd2) && z2) ||
                                ((idx_q == 2'd1) && z1));

    seg_decode u_dec (
        .bcd_i (cur_nib),
        .seg_o (cur_seg)
    );

    // Scan FSM next state: slot counter and digit index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = 2'd3;
                end
                BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) state_d = DRIVE;
                end
                DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q - 2'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd3;
                end
            endcase
        end
    end

    // Pending/active word handling; accept and promote are mutually exclusive
    // because a full pending buffer holds wr_ready low
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        act_d       = act_q;
        if (accept) begin
            pend_d      = wr_data;
            pend_full_d = 1'b1;
        end else if (promote) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end
        wr_ready_d = !pend_full_d;
    end

    // Output patterns derived from the current scan position
    always_comb begin
        seg_d        = SEG_BLANK;
        dig_d        = '0;
        frame_done_d = boundary;
        if (en && (state_q == DRIVE)) begin
            dig_d = 4'b0001 << idx_q;
            seg_d = suppress ? SEG_BLANK : cur_seg;
        end
    end

    // Scan state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Word storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            act_q       <= '0;
            wr_ready_q  <= 1'b1;
        end else begin
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q        <= SEG_BLANK;
            dig_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for a 4-digit multiplexed common-bus 7-segment display. It accepts a 4-digit BCD word through a valid/ready write port and time-shares one segment bus across four digit enables, with a blanking gap between digits. The segment encoding matches the team's single-digit driver. It sits between the counting/datapath logic and the board's segment and digit pins.

## Interface
- `SCAN_DIV`, 1000: clk cycles per digit slot (≥ 2).
- `BLANK_CYC`, 16: blanked cycles at the start of each slot (1 ≤ BLANK_CYC < SCAN_DIV).
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable; 0 forces the display dark.
- `lz_en` in 1: leading-zero suppression enable.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: controller can accept a write.
- `wr_data` in 16: BCD digits, [15:12] = digit 3 (most significant), [3:0] = digit 0.
- `seg` out 8: segments {a,b,c,d,e,f,g,dp}, active-high, MSB = a.
- `dig` out 4: one-hot active-high digit enable, bit n = digit n.
- `frame_done` out 1: one-cycle pulse at the end of each full scan frame.

## Operation
- Storage:
  - `pend` holds one pending word, with flag `pend_full`.
  - `act` holds the displayed word.
  - `wr_ready = !pend_full`, registered.
  - A transfer occurs when `wr_valid && wr_ready`; it loads `pend` and sets `pend_full`.
- Promotion from `pend` to `act` (no frame ever shows mixed words):
  - In IDLE, promotion is immediate on the cycle after acceptance.
  - Otherwise, promotion happens only on the frame-boundary cycle, the last cycle of the digit-0 slot.
  - Promotion clears `pend_full`. `wr_ready` rises on the following cycle.
  - On a boundary cycle with `pend_full = 1`, no new write is accepted, because `wr_ready` is still 0.
- FSM states:
  - IDLE: `seg = 0`, `dig = 0`.
  - BLANK: slot counter `cnt < BLANK_CYC`. `seg = 0`, `dig = 0`.
  - DRIVE: `cnt ≥ BLANK_CYC`. `dig = 1 << idx`, `seg = decode(act[idx])`.
- Transitions:
  - IDLE→BLANK when `en = 1`, with `idx = 3` and `cnt = 0`.
  - BLANK→DRIVE when `cnt = BLANK_CYC-1`.
  - DRIVE→BLANK when `cnt = SCAN_DIV-1`; `cnt` resets to 0 and `idx` decrements, wrapping 0→3.
  - Any state→IDLE when `en = 0`; `cnt` and `idx` reset.
- Scan order is digit 3, 2, 1, 0, repeating.
- `frame_done` pulses on the cycle after DRIVE of digit 0 ends, that is, the cycle after the boundary.
- Decode: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11100110. Nibbles 10–15 decode to 00000000.
- Leading-zero suppression (`lz_en = 1`):
  - Digit n is blanked when it and every higher digit are 0.
  - Digit 0 is never suppressed.
  - `lz_en` is sampled live.

## Timing
- Reset values: `seg = 0`, `dig = 0`, `wr_ready = 1`, `frame_done = 0`, `pend_full = 0`, `act = 16'h0000`, state IDLE, `idx = 3`, `cnt = 0`.
- All outputs are registered. `seg` and `dig` change in the same cycle, so there are no overlapping digit enables.
- Latency from `en` sampled high at edge t:
  - BLANK for edges t+1 … t+BLANK_CYC.
  - Digit 3 drives from t+BLANK_CYC+1.
- Frame length is 4·SCAN_DIV cycles. Each digit is lit SCAN_DIV−BLANK_CYC cycles per frame.
- `en` dropping mid-slot: outputs go to 0 on the next edge; `pend`/`act` are preserved.
- Asynchronous reset mid-frame: all outputs clear immediately; a pending word is lost.
- Write throughput while scanning is at most one word per frame. In IDLE, the write-to-`act` latency is 1 cycle.

## Structure
- Package `seg_pkg`:
  - The ten segment pattern constants and `SEG_BLANK = 8'h00`.
  - FSM state typedef {IDLE, BLANK, DRIVE}.
- Sub-module `seg_decode`: combinational 4-bit BCD → 8-bit pattern.
- Top level: FSM, counters, pend/act registers, and output registers.

## Test plan
All scenarios use `SCAN_DIV = 8`, `BLANK_CYC = 2`.
- Reset, write 16'h1234 in IDLE, `en = 1`:
  - `dig` sequence 1000, 0100, 0010, 0001.
  - `seg` = 01100000, 11011010, 11110010, 01100110 for 6 cycles each, preceded by 2 dark cycles per slot.
  - `frame_done` every 32 cycles.
- `en = 1`, `lz_en = 1`, write 16'h0050:
  - Digits 3 and 2 dark (dig pulses, `seg = 0`).
  - Digit 1 = 10110110, digit 0 = 11111100.
  - Write 16'h0000: only digit 0 shows 11111100.
- Write 16'h1111 then 16'h2222 mid-frame:
  - `wr_ready` low until the boundary.
  - 16'h1111 appears from the next frame.
  - 16'h2222 is accepted after the boundary and shown one frame later; no frame mixes digits.
- Write 16'hAB90 while scanning:
  - Digits 3 and 2 show 00000000.
  - Digit 1 = 11100110, digit 0 = 11111100.
- Drop `en` during DRIVE of digit 2: next cycle `seg = 0`, `dig = 0`. Re-enable: the scan restarts at digit 3 after 2 blank cycles.
- Assert `rst` low mid-DRIVE: outputs clear asynchronously, `wr_ready = 1`, and after release and `en` the display shows 0000.
